ddr_rd_arbiter_rr: RTL and testbench
====================================

# ddr_rd_arbiter_rr

Parametrised read arbiter between N work-unit read ports and the single read channel of the DDR interface. It is the successor to the fixed-configuration DDR arbiter and adds three things:
- configurable port count, address width, data width and outstanding-request depth;
- selectable round-robin or fixed-priority grant;
- an in-order tag FIFO, so several reads can be outstanding before data returns.

It sits in the 300 MHz domain between the work units and `ddr_iface`.

## Interface

Parameters
- N_PORTS, 8: number of requesting work units (2..32).
- ADDR_BITS, 25: DDR address width; codebase value `MEM_ADDRBITS`.
- DATA_WIDTH, 128: read data width; codebase value `MEM_WIDTH`.
- MAX_OUTST, 4: maximum accepted-but-uncompleted reads (power of two, 2..16).

Ports
- i_clk300  in  1  sole clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_mode_fixed  in  1  grant mode: 0 = round-robin, 1 = fixed priority (port 0 highest); quasi-static.
- i_rdata_req  in  N_PORTS  per-port read request level.
- i_raddr  in  N_PORTS*ADDR_BITS  per-port address; port p occupies bits [(p+1)*ADDR_BITS-1 -: ADDR_BITS].
- o_rdata_req_accepted  out  N_PORTS  one-cycle pulse to the port whose request DDR accepted.
- o_rdata  out  DATA_WIDTH  registered read data, broadcast to all ports.
- o_rdata_valid  out  N_PORTS  one-hot qualifier for o_rdata.
- o_rdata_req  out  1  request to `ddr_iface`.
- o_raddr  out  ADDR_BITS  address to `ddr_iface`.
- i_rdata_req_accepted  in  1  `ddr_iface` accepts o_rdata_req this cycle.
- i_rdata  in  DATA_WIDTH  DDR read data.
- i_rdata_valid  in  1  DDR read data valid.
- i_rdata_lastword  in  1  marks the final word of a burst; meaningful only with i_rdata_valid.
- o_outstanding  out  $clog2(MAX_OUTST+1)  current tag FIFO occupancy.
- o_err_orphan  out  1  sticky error: data arrived while no read was outstanding.

## Operation

- Reset values: all outputs 0, tag FIFO empty, round-robin pointer 0, FSM in IDLE.

FSM (two states)
- IDLE: if the FIFO is not full and any i_rdata_req bit is set, the arbiter:
  - selects winner g;
  - registers o_raddr from port g;
  - sets o_rdata_req = 1;
  - moves to ISSUE.
- ISSUE: o_rdata_req and o_raddr stay constant until i_rdata_req_accepted = 1. A request is never retracted, even if the port drops i_rdata_req.
- On acceptance:
  - o_rdata_req_accepted[g] pulses in the same cycle (combinational: ISSUE & i_rdata_req_accepted & grant one-hot);
  - g is pushed into the tag FIFO;
  - o_rdata_req clears on the next edge and the FSM returns to IDLE.
- This gives one bubble cycle between consecutive issues.

Grant rules
- Fixed priority: the lowest set index wins.
- Round-robin: search starts at ptr and wraps modulo N_PORTS. After an accepted grant to g, ptr = (g+1) mod N_PORTS; wrap from N_PORTS-1 goes to 0. ptr changes only on acceptance.
- Changing i_mode_fixed takes effect at the next IDLE decision.

Data return
- On each cycle with i_rdata_valid = 1 and the FIFO non-empty: o_rdata <= i_rdata and o_rdata_valid <= onehot(FIFO head).
- If i_rdata_lastword is also set, the head is popped.

Boundary conditions
- Push and pop in the same cycle: occupancy unchanged.
- FIFO full: no new issue; IDLE waits until a pop.
- i_rdata_valid while the FIFO is empty:
  - data is dropped and o_rdata_valid stays 0;
  - o_err_orphan is set and held until reset.
- Occupancy counter wrap is impossible by construction; a push while full is an assertion failure in simulation.
- Reset mid-burst: FIFO, FSM and ptr clear immediately (asynchronously). Data still arriving afterwards flags o_err_orphan; `ddr_iface` shares the reset, so this indicates a system fault.

## Timing

- Request-to-DDR latency: i_rdata_req rising in IDLE gives o_rdata_req high one cycle later.
- Acceptance pulse: same cycle as i_rdata_req_accepted.
- Earliest re-issue: two cycles after the previous issue (one bubble).
- Data latency: exactly one cycle from i_rdata_valid to o_rdata_valid, with no gaps inserted.
- Returned data is strictly in acceptance order.

## Structure

- Parameter defaults come from `defs.vh` (`N_UNITS`, `MEM_ADDRBITS`, `MEM_WIDTH`); add `MAX_OUTST_DEFAULT` there as well.
- One sub-module, `tag_fifo`: a synchronous FIFO of width $clog2(N_PORTS) and depth MAX_OUTST, with push, pop, head, count and full/empty outputs.
- Winner selection is a combinational function in the top module: a rotate-by-ptr priority encoder that degenerates to ptr = 0 in fixed mode.

## Test plan

- Round-robin order: N_PORTS = 4, all requests held, DDR always accepting → accepted pulses on ports 0, 1, 2, 3, 0, with the address on each issue matching the granted port.
- Fixed priority: i_mode_fixed = 1, ports 1 and 3 requesting continuously → port 1 granted every time and port 3 never granted; release port 1 → port 3 granted at the next IDLE.
- Tag ordering: MAX_OUTST = 4; ports 2, 0, 3 accepted; three 4-word bursts returned → o_rdata_valid one-hot 0100 ×4, then 0001 ×4, then 1000 ×4, each one cycle after its input word, with o_outstanding stepping 3 → 2 → 1 → 0.
- FIFO full: 4 accepted reads with no data returned, 5th request pending → o_rdata_req stays 0. Return the first lastword → the 5th request issues the cycle after the pop, and o_outstanding reaches 4 again.
- Orphan data: i_rdata_valid with an empty FIFO → o_rdata_valid = 0 and o_err_orphan = 1, held across later valid traffic.
- Reset mid-operation: assert i_reset during ISSUE with 2 reads outstanding → all outputs 0 immediately. Round-robin restarts at port 0 after release.

Source files
------------

// File: rtl/ddr_rd_arbiter_rr_pkg.sv
// Shared defaults and FSM encodings for the DDR read arbiter.
// Default parameter values track the codebase memory configuration.
package ddr_rd_arbiter_rr_pkg;

    localparam int N_UNITS           = 8;
    localparam int MEM_ADDRBITS      = 25;
    localparam int MEM_WIDTH         = 128;
    localparam int MAX_OUTST_DEFAULT = 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

endpackage

// File: rtl/ddr_rd_arbiter_rr_chk.sv
// Simulation checks for the read arbiter: the tag FIFO must never see a push while full.
module ddr_rd_arbiter_rr_chk (
    input logic clk,
    input logic rst,
    input logic push,
    input logic full
);

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/ddr_rd_arbiter_rr_tag_fifo.sv
// In-order tag FIFO holding the granted port index of every accepted read.
// Push while full and pop while empty are ignored.
module ddr_rd_arbiter_rr_tag_fifo #(
    parameter int W     = 3,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Tag storage; contents are only read while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr_rd_arbiter_rr.sv
// Read arbiter between N work-unit read ports and the single DDR read channel,
// with round-robin or fixed-priority grant and in-order routing of returned data.
module ddr_rd_arbiter_rr
    import ddr_rd_arbiter_rr_pkg::*;
#(
    parameter int N_PORTS    = N_UNITS,
    parameter int ADDR_BITS  = MEM_ADDRBITS,
    parameter int DATA_WIDTH = MEM_WIDTH,
    parameter int MAX_OUTST  = MAX_OUTST_DEFAULT
) (
    input  logic                           i_clk300,
    input  logic                           i_reset,
    input  logic                           i_mode_fixed,
    input  logic [N_PORTS-1:0]             i_rdata_req,
    input  logic [N_PORTS*ADDR_BITS-1:0]   i_raddr,
    output logic [N_PORTS-1:0]             o_rdata_req_accepted,
    output logic [DATA_WIDTH-1:0]          o_rdata,
    output logic [N_PORTS-1:0]             o_rdata_valid,
    output logic                           o_rdata_req,
    output logic [ADDR_BITS-1:0]           o_raddr,
    input  logic                           i_rdata_req_accepted,
    input  logic [DATA_WIDTH-1:0]          i_rdata,
    input  logic                           i_rdata_valid,
    input  logic                           i_rdata_lastword,
    output logic [$clog2(MAX_OUTST+1)-1:0] o_outstanding,
    output logic                           o_err_orphan
);

    localparam int IW = $clog2(N_PORTS);
    localparam int CW = $clog2(MAX_OUTST + 1);

    logic [0:0]           state;
    logic [IW-1:0]        grant;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        start;
    logic [IW-1:0]        win;
    logic [IW-1:0]        head;
    logic [ADDR_BITS-1:0] port_addr [N_PORTS];
    logic                 accept;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [CW-1:0]        count;

    // Rotate-by-start priority encoder: first requesting port at or after start, wrapping.
    function automatic logic [IW-1:0] pick_winner(input logic [N_PORTS-1:0] req,
                                                  input logic [IW-1:0]      first);
        logic          found;
        logic [IW-1:0] sel;
        logic [IW-1:0] idx;
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            idx = IW'((int'(first) + i) % N_PORTS);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end else begin
                found = found;
            end
        end
        return sel;
    endfunction

    function automatic logic [N_PORTS-1:0] onehot(input logic [IW-1:0] idx);
        logic [N_PORTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    for (genvar p = 0; p < N_PORTS; p++) begin : g_addr
        assign port_addr[p] = i_raddr[(p+1)*ADDR_BITS-1 -: ADDR_BITS];
    end

    assign accept        = (state == ST_ISSUE) && i_rdata_req_accepted;
    assign pop           = i_rdata_valid && i_rdata_lastword && !empty;
    assign o_outstanding = count;

    // Winner selection; fixed priority is simply a search starting at port 0.
    always_comb begin
        start = i_mode_fixed ? '0 : ptr;
        win   = pick_winner(i_rdata_req, start);
    end

    // Acceptance pulse follows the DDR handshake in the same cycle.
    always_comb begin
        o_rdata_req_accepted = '0;
        if (accept) begin
            o_rdata_req_accepted = onehot(grant);
        end else begin
            o_rdata_req_accepted = '0;
        end
    end

    // Issue FSM: latch winner and address, hold the request until DDR accepts it.
    always_ff @(posedge i_clk300 or posedge i_reset) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            grant       <= '0;
            ptr         <= '0;
            o_rdata_req <= 1'b0;
            o_raddr     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!full && (|i_rdata_req)) begin
                        grant       <= win;
                        o_raddr     <= port_addr[win];
                        o_rdata_req <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (i_rdata_req_accepted) begin
                        o_rdata_req <= 1'b0;
                        state       <= ST_IDLE;
                        ptr         <= (grant == IW'(N_PORTS - 1)) ? '0 : grant + IW'(1);
                    end
                end
                default: begin
                    o_rdata_req <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    // Return path: route each data word to the oldest outstanding requester.
    always_ff @(posedge i_clk300 or posedge i_reset) begin
        if (i_reset) begin
            o_rdata       <= '0;
            o_rdata_valid <= '0;
            o_err_orphan  <= 1'b0;
        end else begin
            if (i_rdata_valid && !empty) begin
                o_rdata       <= i_rdata;
                o_rdata_valid <= onehot(head);
            end else begin
                o_rdata_valid <= '0;
            end
            if (i_rdata_valid && empty) begin
                o_err_orphan <= 1'b1;
            end
        end
    end

    ddr_rd_arbiter_rr_tag_fifo #(
        .W     (IW),
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .clk       (i_clk300),
        .rst       (i_reset),
        .push      (accept),
        .push_data (grant),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    ddr_rd_arbiter_rr_chk u_chk (
        .clk  (i_clk300),
        .rst  (i_reset),
        .push (accept),
        .full (full)
    );

endmodule

// File: tb/tb_ddr_rd_arbiter_rr.sv
// Directed self-checking bench for ddr_rd_arbiter_rr with 4 ports and 4 outstanding reads.
module tb_ddr_rd_arbiter_rr;

    localparam int NP = 4;
    localparam int AB = 8;
    localparam int DW = 16;
    localparam int MO = 4;

    logic            clk = 1'b0;
    logic            i_reset;
    logic            i_mode_fixed;
    logic [NP-1:0]   i_rdata_req;
    logic [NP*AB-1:0] i_raddr;
    logic [NP-1:0]   o_rdata_req_accepted;
    logic [DW-1:0]   o_rdata;
    logic [NP-1:0]   o_rdata_valid;
    logic            o_rdata_req;
    logic [AB-1:0]   o_raddr;
    logic            i_rdata_req_accepted;
    logic [DW-1:0]   i_rdata;
    logic            i_rdata_valid;
    logic            i_rdata_lastword;
    logic [2:0]      o_outstanding;
    logic            o_err_orphan;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ddr_rd_arbiter_rr #(
        .N_PORTS    (NP),
        .ADDR_BITS  (AB),
        .DATA_WIDTH (DW),
        .MAX_OUTST  (MO)
    ) dut (
        .i_clk300             (clk),
        .i_reset              (i_reset),
        .i_mode_fixed         (i_mode_fixed),
        .i_rdata_req          (i_rdata_req),
        .i_raddr              (i_raddr),
        .o_rdata_req_accepted (o_rdata_req_accepted),
        .o_rdata              (o_rdata),
        .o_rdata_valid        (o_rdata_valid),
        .o_rdata_req          (o_rdata_req),
        .o_raddr              (o_raddr),
        .i_rdata_req_accepted (i_rdata_req_accepted),
        .i_rdata              (i_rdata),
        .i_rdata_valid        (i_rdata_valid),
        .i_rdata_lastword     (i_rdata_lastword),
        .o_outstanding        (o_outstanding),
        .o_err_orphan         (o_err_orphan)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (o_rdata_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, 32'(o_rdata_req), 32'd1);
    endtask

    // Port p drives address 0xA0+p, so the expected address is 160+p.
    task automatic issue_only(input int port, input logic [3:0] next_req);
        wait_req("io");
        chk("io_addr", 32'(o_raddr), 32'(160 + port));
        chk("io_acc", 32'(o_rdata_req_accepted), 32'(1 << port));
        i_rdata_req = next_req;
        tick();
    endtask

    task automatic issue_and_pop(input int port, input logic [3:0] next_req, input logic [15:0] data);
        wait_req("ip");
        chk("ip_addr", 32'(o_raddr), 32'(160 + port));
        chk("ip_acc", 32'(o_rdata_req_accepted), 32'(1 << port));
        tick();
        chk("ip_bubble", 32'(o_rdata_req), 32'd0);
        i_rdata_valid    = 1'b1;
        i_rdata_lastword = 1'b1;
        i_rdata          = data;
        i_rdata_req      = next_req;
        tick();
        chk("ip_vld", 32'(o_rdata_valid), 32'(1 << port));
        chk("ip_data", 32'(o_rdata), 32'(data));
        i_rdata_valid    = 1'b0;
        i_rdata_lastword = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        i_reset              = 1'b1;
        i_mode_fixed         = 1'b0;
        i_rdata_req          = 4'b0000;
        i_raddr              = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        i_rdata_req_accepted = 1'b0;
        i_rdata              = 16'h0000;
        i_rdata_valid        = 1'b0;
        i_rdata_lastword     = 1'b0;
        repeat (3) tick();

        chk("rst_req", 32'(o_rdata_req), 32'd0);
        chk("rst_addr", 32'(o_raddr), 32'd0);
        chk("rst_vld", 32'(o_rdata_valid), 32'd0);
        chk("rst_acc", 32'(o_rdata_req_accepted), 32'd0);
        chk("rst_cnt", 32'(o_outstanding), 32'd0);
        chk("rst_err", 32'(o_err_orphan), 32'd0);
        chk("rst_data", 32'(o_rdata), 32'd0);

        // Round-robin with all ports requesting: 0,1,2,3,0
        i_rdata_req          = 4'b1111;
        i_rdata_req_accepted = 1'b1;
        i_reset              = 1'b0;
        chk("lat0", 32'(o_rdata_req), 32'd0);
        tick();
        chk("lat1", 32'(o_rdata_req), 32'd1);
        for (int k = 0; k < 5; k++) begin
            issue_and_pop(k % 4, (k == 4) ? 4'b0000 : 4'b1111, 16'(k + 1));
        end
        tick();

        // Fixed priority: port 1 beats port 3 until it lets go
        i_mode_fixed = 1'b1;
        i_rdata_req  = 4'b1010;
        issue_and_pop(1, 4'b1010, 16'h0011);
        issue_and_pop(1, 4'b1010, 16'h0012);
        issue_and_pop(1, 4'b1000, 16'h0013);
        issue_and_pop(3, 4'b0000, 16'h0014);
        i_mode_fixed = 1'b0;
        tick();

        // Tag ordering: accept 2, 0, 3 then return three 4-word bursts
        i_rdata_req = 4'b0100;
        issue_only(2, 4'b0001);
        issue_only(0, 4'b1000);
        issue_only(3, 4'b0000);
        chk("to_cnt", 32'(o_outstanding), 32'd3);
        for (int b = 0; b < 3; b++) begin
            for (int w = 0; w < 4; w++) begin
                i_rdata_valid    = 1'b1;
                i_rdata_lastword = (w == 3);
                i_rdata          = 16'(b * 16 + w);
                tick();
                chk("to_vld", 32'(o_rdata_valid), (b == 0) ? 32'h4 : ((b == 1) ? 32'h1 : 32'h8));
                chk("to_data", 32'(o_rdata), 32'(b * 16 + w));
                chk("to_cnt_step", 32'(o_outstanding), 32'((w == 3) ? (2 - b) : (3 - b)));
            end
        end
        i_rdata_valid    = 1'b0;
        i_rdata_lastword = 1'b0;
        tick();
        chk("to_vld_idle", 32'(o_rdata_valid), 32'd0);

        // FIFO full: four accepts, fifth waits for a pop
        i_rdata_req = 4'b1111;
        issue_only(0, 4'b1111);
        issue_only(1, 4'b1111);
        issue_only(2, 4'b1111);
        issue_only(3, 4'b1111);
        chk("full_cnt", 32'(o_outstanding), 32'd4);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_hold", 32'(o_rdata_req), 32'd0);
        end
        i_rdata_valid    = 1'b1;
        i_rdata_lastword = 1'b1;
        i_rdata          = 16'h0055;
        tick();
        chk("full_pop_vld", 32'(o_rdata_valid), 32'h1);
        chk("full_pop_req", 32'(o_rdata_req), 32'd0);
        chk("full_pop_cnt", 32'(o_outstanding), 32'd3);
        i_rdata_valid    = 1'b0;
        i_rdata_lastword = 1'b0;
        tick();
        chk("full_reissue", 32'(o_rdata_req), 32'd1);
        chk("full_reissue_addr", 32'(o_raddr), 32'hA0);
        chk("full_reissue_acc", 32'(o_rdata_req_accepted), 32'h1);
        i_rdata_req = 4'b0000;
        tick();
        chk("full_cnt2", 32'(o_outstanding), 32'd4);

        // Reset during ISSUE with two reads outstanding
        i_rdata_valid    = 1'b1;
        i_rdata_lastword = 1'b1;
        tick();
        tick();
        i_rdata_valid        = 1'b0;
        i_rdata_lastword     = 1'b0;
        i_rdata_req          = 4'b0010;
        i_rdata_req_accepted = 1'b0;
        tick();
        chk("mr_req", 32'(o_rdata_req), 32'd1);
        chk("mr_cnt", 32'(o_outstanding), 32'd2);
        chk("mr_addr", 32'(o_raddr), 32'hA1);
        i_rdata_req_accepted = 1'b1;
        #1;
        chk("mr_acc", 32'(o_rdata_req_accepted), 32'h2);
        i_reset = 1'b1;
        #1;
        chk("mr_rst_req", 32'(o_rdata_req), 32'd0);
        chk("mr_rst_addr", 32'(o_raddr), 32'd0);
        chk("mr_rst_cnt", 32'(o_outstanding), 32'd0);
        chk("mr_rst_acc", 32'(o_rdata_req_accepted), 32'd0);
        chk("mr_rst_vld", 32'(o_rdata_valid), 32'd0);
        chk("mr_rst_err", 32'(o_err_orphan), 32'd0);
        chk("mr_rst_data", 32'(o_rdata), 32'd0);
        tick();
        i_rdata_req = 4'b1111;
        i_reset     = 1'b0;
        issue_and_pop(0, 4'b0000, 16'h0077);
        chk("mr_cnt_end", 32'(o_outstanding), 32'd0);

        // Orphan data with empty FIFO, then normal traffic keeps the flag
        i_rdata_valid    = 1'b1;
        i_rdata_lastword = 1'b1;
        i_rdata          = 16'hBEEF;
        tick();
        chk("orph_vld", 32'(o_rdata_valid), 32'd0);
        chk("orph_err", 32'(o_err_orphan), 32'd1);
        chk("orph_cnt", 32'(o_outstanding), 32'd0);
        i_rdata_valid    = 1'b0;
        i_rdata_lastword = 1'b0;
        i_rdata_req      = 4'b0100;
        issue_and_pop(2, 4'b0000, 16'h0099);
        chk("orph_err_held", 32'(o_err_orphan), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
